// File: rtl/dbus_sram_responder_if.sv
// dbus_sram_responder_if: core data-bus request/response bundle.
interface dbus_sram_responder_if;
    typedef logic [2:0] msize_t;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    modport master (output dreq, input dresp);
    modport slave (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: latency-programmable SRAM backing store behind the core data bus.
module dbus_sram_responder #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input logic clk,
    input logic reset,
    dbus_sram_responder_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [63:0] addr, wdata, off, rdata;
    logic [7:0] strobe;
    logic [63:0] mem [MEM_WORDS];
    logic [AW-1:0] idx;
    logic in_range, resp, we, unused;

    if (LATENCY < 0 || LATENCY > 15) begin : g_lat_err
        $error("LATENCY must be within 0..15");
    end
    if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_words_err
        $error("MEM_WORDS must be a power of two >= 2");
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            addr   <= '0;
            strobe <= '0;
            wdata  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && bus.dreq.valid) begin
                addr   <= bus.dreq.addr;
                strobe <= bus.dreq.strobe;
                wdata  <= bus.dreq.data;
            end
        end
    end

    // Dropping valid anywhere past acceptance abandons the request.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == IDLE) begin
            if (bus.dreq.valid) begin
                cnt_nxt   = 4'(LATENCY);
                state_nxt = (LATENCY == 0) ? RESP : WAIT;
            end
        end else if (!bus.dreq.valid) begin
            state_nxt = IDLE;
        end else if (state == WAIT) begin
            cnt_nxt   = cnt - 4'd1;
            state_nxt = (cnt == 4'd1) ? RESP : WAIT;
        end else begin
            state_nxt = IDLE;
        end
    end

    assign off      = addr - BASE_ADDR;
    assign in_range = (addr >= BASE_ADDR) && (off[63:3+AW] == '0);
    assign idx      = off[3 +: AW];
    assign resp     = (state == RESP);
    assign we       = resp && bus.dreq.valid && (strobe != 8'h00) && in_range;
    assign rdata    = (resp && strobe == 8'h00 && in_range) ? mem[idx] : 64'd0;
    assign bus.dresp = {resp, resp, rdata};
    assign unused   = ^{bus.dreq.size, off[2:0]};

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb_dbus_sram_responder: directed checks on a LATENCY=2 and a LATENCY=0 responder.
module tb_dbus_sram_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    dbus_sram_responder_if bus2 ();
    dbus_sram_responder_if bus0 ();

    dbus_sram_responder #(.MEM_WORDS(16), .LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    dbus_sram_responder #(.MEM_WORDS(16), .LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    task automatic drive(input bit s, input logic v, input logic [63:0] a, input logic [7:0] st, input logic [63:0] d);
        if (s) begin
            bus0.dreq.valid = v; bus0.dreq.addr = a; bus0.dreq.size = 3'd3;
            bus0.dreq.strobe = st; bus0.dreq.data = d;
        end else begin
            bus2.dreq.valid = v; bus2.dreq.addr = a; bus2.dreq.size = 3'd3;
            bus2.dreq.strobe = st; bus2.dreq.data = d;
        end
    endtask

    function automatic logic dok(input bit s);
        return s ? bus0.dresp.data_ok : bus2.dresp.data_ok;
    endfunction

    function automatic logic aok(input bit s);
        return s ? bus0.dresp.addr_ok : bus2.dresp.addr_ok;
    endfunction

    function automatic logic [63:0] rdat(input bit s);
        return s ? bus0.dresp.data : bus2.dresp.data;
    endfunction

    // One full transaction started at a negedge; lat counts negedges until data_ok (-1 = none).
    task automatic req(input bit s, input logic [63:0] a, input logic [7:0] st, input logic [63:0] d,
                       output int lat, output logic [63:0] rd, output logic ao, output logic extra);
        lat = -1; rd = 'x; ao = 1'bx;
        drive(s, 1'b1, a, st, d);
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(negedge clk);
            if (dok(s) === 1'b1) begin lat = i; rd = rdat(s); ao = aok(s); end
        end
        @(negedge clk);
        extra = dok(s);
        drive(s, 1'b0, a, st, d);
    endtask

    task automatic test_reset();
        int lat = -1;
        logic bad;
        reset = 1'b1;
        drive(0, 1'b1, 64'h8000_0000, 8'h00, 64'd0);
        drive(1, 1'b0, 64'd0, 8'h00, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bad = bus2.dresp.addr_ok | bus2.dresp.data_ok | (|bus2.dresp.data);
            total++;
            if (bad !== 1'b0) $display("FAIL reset_outputs cycle %0d got %b want 0", i, bad); else pass_cnt++;
        end
        reset = 1'b0;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (bus2.dresp.data_ok === 1'b1) lat = i;
        end
        total++;
        if (lat !== 3) $display("FAIL reset_release_latency got %0d want 3", lat); else pass_cnt++;
        @(negedge clk);
        drive(0, 1'b0, 64'd0, 8'h00, 64'd0);
    endtask

    task automatic test_latency();
        int lat;
        logic [63:0] rd;
        logic ao, ex;
        req(0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, lat, rd, ao, ex);
        total++;
        if (lat !== 3 || rd !== 64'd0) $display("FAIL write_resp lat %0d data %h want 3 / 0", lat, rd); else pass_cnt++;
        req(0, 64'h8000_0010, 8'h00, 64'd0, lat, rd, ao, ex);
        total++;
        if (lat !== 3) $display("FAIL read_latency got %0d want 3", lat); else pass_cnt++;
        total++;
        if (rd !== 64'h1122_3344_5566_7788) $display("FAIL read_data got %h want 1122334455667788", rd); else pass_cnt++;
        total++;
        if (ao !== 1'b1 || ex !== 1'b0) $display("FAIL read_single_cycle addr_ok %b next data_ok %b want 1/0", ao, ex); else pass_cnt++;
    endtask

    task automatic test_strobe();
        int lat;
        logic [63:0] rd;
        logic ao, ex;
        req(0, 64'h8000_0008, 8'hFF, 64'd0, lat, rd, ao, ex);
        req(0, 64'h8000_0008, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, lat, rd, ao, ex);
        req(0, 64'h8000_0008, 8'h00, 64'd0, lat, rd, ao, ex);
        total++;
        if (rd !== 64'h0000_0000_CCCC_DDDD) $display("FAIL strobe_0f got %h want 00000000ccccdddd", rd); else pass_cnt++;
        req(0, 64'h8000_0018, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, rd, ao, ex);
        req(0, 64'h8000_0018, 8'hA5, 64'h0102_0304_0506_0708, lat, rd, ao, ex);
        req(0, 64'h8000_001D, 8'h00, 64'd0, lat, rd, ao, ex);
        total++;
        if (rd !== 64'h01FF_03FF_FF06_FF08) $display("FAIL strobe_a5 got %h want 01ff03ffff06ff08", rd); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [63:0] rd;
        logic ao, ex;
        req(0, 64'h8000_0000, 8'hFF, 64'h0000_0000_0000_00A0, lat, rd, ao, ex);
        req(0, 64'h8000_0078, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, lat, rd, ao, ex);
        req(0, 64'h7FFF_FFF8, 8'h00, 64'd0, lat, rd, ao, ex);
        total++;
        if (lat !== 3 || rd !== 64'd0) $display("FAIL oor_read_low lat %0d data %h want 3 / 0", lat, rd); else pass_cnt++;
        req(0, 64'h8000_0080, 8'h00, 64'd0, lat, rd, ao, ex);
        total++;
        if (lat !== 3 || rd !== 64'd0) $display("FAIL oor_read_high lat %0d data %h want 3 / 0", lat, rd); else pass_cnt++;
        req(0, 64'h8000_0080, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, lat, rd, ao, ex);
        total++;
        if (lat !== 3) $display("FAIL oor_write_resp lat %0d want 3", lat); else pass_cnt++;
        req(0, 64'h7FFF_FFF8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, lat, rd, ao, ex);
        req(0, 64'h8000_0000, 8'h00, 64'd0, lat, rd, ao, ex);
        total++;
        if (rd !== 64'h0000_0000_0000_00A0) $display("FAIL oor_word0_kept got %h want 00000000000000a0", rd); else pass_cnt++;
        req(0, 64'h8000_0078, 8'h00, 64'd0, lat, rd, ao, ex);
        total++;
        if (rd !== 64'h0F0F_0F0F_0F0F_0F0F) $display("FAIL oor_word15_kept got %h want 0f0f0f0f0f0f0f0f", rd); else pass_cnt++;
    endtask

    task automatic test_abort();
        int lat;
        int seen = 0;
        logic [63:0] rd;
        logic ao, ex;
        drive(0, 1'b1, 64'h8000_0010, 8'hFF, 64'h9999_9999_9999_9999);
        @(negedge clk);
        drive(0, 1'b0, 64'h8000_0010, 8'hFF, 64'h9999_9999_9999_9999);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus2.dresp.data_ok !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL abort_no_resp data_ok seen %0d times want 0", seen); else pass_cnt++;
        req(0, 64'h8000_0010, 8'h00, 64'd0, lat, rd, ao, ex);
        total++;
        if (rd !== 64'h1122_3344_5566_7788) $display("FAIL abort_word_kept got %h want 1122334455667788", rd); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int lat = -1;
        logic [63:0] rd;
        logic ao, ex;
        drive(0, 1'b1, 64'h8000_0010, 8'hFF, 64'h5555_5555_5555_5555);
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (bus2.dresp.data_ok === 1'b1) lat = i;
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if (bus2.dresp.data_ok !== 1'b0 || bus2.dresp.addr_ok !== 1'b0)
            $display("FAIL async_reset_outputs data_ok %b addr_ok %b want 0/0", bus2.dresp.data_ok, bus2.dresp.addr_ok);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, 64'd0, 8'h00, 64'd0);
        req(0, 64'h8000_0010, 8'h00, 64'd0, lat, rd, ao, ex);
        total++;
        if (lat !== 3 || rd !== 64'h1122_3344_5566_7788)
            $display("FAIL async_reset_write_dropped lat %0d data %h want 3 / 1122334455667788", lat, rd);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [63:0] rd;
        logic ao, ex;
        logic [63:0] exp_data [5];
        logic [63:0] seq_addr [5];
        logic [7:0] seq_strb [5];
        logic [63:0] seq_data [5];
        int k = 0;
        req(1, 64'h8000_0020, 8'hFF, 64'h4444_4444_4444_4444, lat, rd, ao, ex);
        total++;
        if (lat !== 1) $display("FAIL lat0_latency got %0d want 1", lat); else pass_cnt++;
        req(1, 64'h8000_0028, 8'hFF, 64'h5555_5555_5555_5555, lat, rd, ao, ex);
        req(1, 64'h8000_0030, 8'hFF, 64'h6666_6666_6666_6666, lat, rd, ao, ex);
        req(1, 64'h8000_0038, 8'hFF, 64'h7777_7777_7777_7777, lat, rd, ao, ex);
        seq_addr = '{64'h8000_0020, 64'h8000_0020, 64'h8000_0028, 64'h8000_0030, 64'h8000_0038};
        seq_strb = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        seq_data = '{64'hA4A4_A4A4_A4A4_A4A4, 64'd0, 64'd0, 64'd0, 64'd0};
        exp_data = '{64'd0, 64'hA4A4_A4A4_A4A4_A4A4, 64'h5555_5555_5555_5555,
                     64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777};
        drive(1, 1'b1, seq_addr[0], seq_strb[0], seq_data[0]);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (bus0.dresp.data_ok !== ((c % 2) == 0))
                $display("FAIL b2b_data_ok cycle %0d got %b want %b", c, bus0.dresp.data_ok, (c % 2) == 0);
            else pass_cnt++;
            if ((c % 2) == 0) begin
                total++;
                if (bus0.dresp.data !== exp_data[k])
                    $display("FAIL b2b_data item %0d got %h want %h", k, bus0.dresp.data, exp_data[k]);
                else pass_cnt++;
                k++;
                if (k < 5) drive(1, 1'b1, seq_addr[k], seq_strb[k], seq_data[k]);
            end else if (k == 5) begin
                drive(1, 1'b0, 64'd0, 8'h00, 64'd0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_strobe();
        test_out_of_range();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
